// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
// States, CRC-16-CCITT constants and a word-count helper.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CRC_WAIT = 3'd3,
    ST_DONE     = 3'd4
  } ccff_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic int words_per_load(
    input int chain_len,
    input int word_w
  );
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT, MSB feedback, one bit per enabled cycle.
// Used by the loader only when CCFF_LOADER_CRC_EN is defined.
module ccff_crc16_serial
  import ccff_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic fb;

  assign fb = crc[15] ^ din;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words onto the config chain head, LSB first.
// Optional trailing CRC check: define CCFF_LOADER_CRC_EN.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              bs_valid,
  input  logic [WORD_W-1:0] bs_data,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
`ifdef CCFF_LOADER_CRC_EN
  ,
  output logic              crc_err
`endif
);

  localparam int WB_W = $clog2(WORD_W + 1);

`ifdef CCFF_LOADER_CRC_EN
  localparam ccff_state_e END_ST = ST_CRC_WAIT;
`else
  localparam ccff_state_e END_ST = ST_DONE;
`endif

  ccff_state_e       state;
  ccff_state_e       state_nxt;
  logic [WORD_W-1:0] shreg;
  logic [WB_W-1:0]   word_bits;
  logic [WB_W-1:0]   wb_load;
  logic [31:0]       remaining;
  logic              last_bit;
  logic              chain_full;
  logic              crc_go;

  // Final word may be partial: only the bits the chain still needs.
  assign remaining  = 32'(CHAIN_LEN) - 32'(bit_count);
  assign wb_load    = (remaining < 32'(WORD_W)) ?
                      remaining[WB_W-1:0] : WB_W'(WORD_W);
  assign last_bit   = (word_bits == WB_W'(1));
  assign chain_full = (32'(bit_count) + 32'd1) == 32'(CHAIN_LEN);

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (bs_valid) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_bit) begin
          state_nxt = chain_full ? END_ST : ST_LOAD;
        end
      end
      ST_CRC_WAIT: begin
        if (crc_go) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bs_ready      = 1'b0;
    ccff_shift_en = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    unique case (state)
      ST_LOAD: begin
        bs_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_SHIFT: begin
        ccff_shift_en = 1'b1;
        busy          = 1'b1;
      end
      ST_CRC_WAIT: begin
        bs_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign ccff_head = ccff_shift_en & shreg[0];

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      shreg     <= '0;
      word_bits <= '0;
      bit_count <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) bit_count <= '0;
        end
        ST_LOAD: begin
          if (bs_valid) begin
            shreg     <= bs_data;
            word_bits <= wb_load;
          end
        end
        ST_SHIFT: begin
          shreg     <= shreg >> 1;
          bit_count <= bit_count + CNT_W'(1);
          word_bits <= word_bits - WB_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef CCFF_LOADER_CRC_EN
  localparam int CRC_WORDS = words_per_load(16, WORD_W);
  localparam int RX_W      = CRC_WORDS * WORD_W;

  logic [15:0]             crc_val;
  logic [RX_W-1:0]         crc_rx;
  logic [RX_W-1:0]         crc_rx_nxt;
  logic [RX_W+WORD_W-1:0]  rx_cat;
  logic [4:0]              crc_word;
  logic                    crc_clr;

  assign crc_clr = start && (state == ST_IDLE || state == ST_DONE);

  // Narrow words arrive low half first, so new words enter at the top.
  assign rx_cat     = {bs_data, crc_rx};
  assign crc_rx_nxt = rx_cat[RX_W+WORD_W-1:WORD_W];
  assign crc_go     = bs_valid && (crc_word == 5'(CRC_WORDS - 1));

  ccff_crc16_serial u_crc (
    .clk (prog_clk),
    .rst (prog_reset),
    .clr (crc_clr),
    .en  (ccff_shift_en),
    .din (ccff_head),
    .crc (crc_val)
  );

  always_ff @(posedge prog_clk) begin
    if (prog_reset || crc_clr) begin
      crc_rx   <= '0;
      crc_word <= '0;
      crc_err  <= 1'b0;
    end else if (state == ST_CRC_WAIT && bs_valid) begin
      crc_rx   <= crc_rx_nxt;
      crc_word <= crc_word + 5'd1;
      if (crc_go) crc_err <= (crc_rx_nxt[15:0] != crc_val);
    end
  end
`else
  assign crc_go = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: two chain lengths, random words,
// checked against a bit-list / cycle-count model of the load.
module tb_ccff_bitstream_loader;

  localparam int WW  = 8;
  localparam int CL0 = 16;
  localparam int CL1 = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst      [2];
  logic          start    [2];
  logic          bs_valid [2];
  logic [WW-1:0] bs_data  [2];
  logic          bs_ready [2];
  logic          head     [2];
  logic          sen      [2];
  logic          busy     [2];
  logic          done     [2];
  logic [4:0]    bcnt     [2];
`ifdef CCFF_LOADER_CRC_EN
  logic          crc_err  [2];
`endif

  ccff_bitstream_loader #(.CHAIN_LEN(CL0), .WORD_W(WW)) dut0 (
    .prog_clk      (clk),
    .prog_reset    (rst[0]),
    .start         (start[0]),
    .bs_valid      (bs_valid[0]),
    .bs_data       (bs_data[0]),
    .bs_ready      (bs_ready[0]),
    .ccff_head     (head[0]),
    .ccff_shift_en (sen[0]),
    .busy          (busy[0]),
    .done          (done[0]),
    .bit_count     (bcnt[0])
`ifdef CCFF_LOADER_CRC_EN
    ,
    .crc_err       (crc_err[0])
`endif
  );

  ccff_bitstream_loader #(.CHAIN_LEN(CL1), .WORD_W(WW)) dut1 (
    .prog_clk      (clk),
    .prog_reset    (rst[1]),
    .start         (start[1]),
    .bs_valid      (bs_valid[1]),
    .bs_data       (bs_data[1]),
    .bs_ready      (bs_ready[1]),
    .ccff_head     (head[1]),
    .ccff_shift_en (sen[1]),
    .busy          (busy[1]),
    .done          (done[1]),
    .bit_count     (bcnt[1])
`ifdef CCFF_LOADER_CRC_EN
    ,
    .crc_err       (crc_err[1])
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  int gap      = 0;
  int start_at = 0;
  int rst_at   = 0;
  bit bad_crc  = 1'b0;

  logic [WW-1:0] chain_q [$];
  logic [WW-1:0] tx_q    [$];
  bit            exp_bits[$];
  int            exp_runs[$];
  int            exp_done;

  bit obs_head[$];
  int obs_cnt [$];
  int obs_runs[$];
  int done_cyc, leak, rdy_sh, post_bad, busy_drop;
  logic c1_busy, c1_done;
  logic [4:0] c1_cnt;
  logic rst_se, rst_busy, rst_done;
  logic [4:0] rst_cnt;
  bit aborted;

  function automatic int clen(input int d);
    return (d == 0) ? CL0 : CL1;
  endfunction

  task automatic rand_words(input int d);
    chain_q.delete();
    for (int i = 0; i < (clen(d) + WW - 1) / WW; i++)
      chain_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Model: chain gets words LSB-first, truncated to the chain length;
  // each word costs (gap + 1) LOAD cycles plus one cycle per bit.
  task automatic build(input int d);
    int k;
    logic [15:0] c;
    bit fb;
    exp_bits.delete();
    exp_runs.delete();
    tx_q = chain_q;
    exp_done = 1;
    foreach (chain_q[i]) begin
      k = 0;
      for (int b = 0; b < WW; b++) begin
        if (exp_bits.size() < clen(d)) begin
          exp_bits.push_back(chain_q[i][b]);
          k++;
        end
      end
      exp_runs.push_back(k);
      exp_done += gap + 1 + k;
    end
    c = 16'hFFFF;
    foreach (exp_bits[i]) begin
      fb = c[15] ^ exp_bits[i];
      c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    if (bad_crc) c = c ^ 16'h0001;
`ifdef CCFF_LOADER_CRC_EN
    for (int w = 0; w < (16 + WW - 1) / WW; w++) begin
      tx_q.push_back(WW'(c >> (w * WW)));
      exp_done += gap + 1;
    end
`endif
  endtask

  task automatic run_load(input int d);
    int cyc, widx, wt, nsh, run;
    bit pend;
    cyc = 1; widx = 0; wt = 0; nsh = 0; run = 0; pend = 0;
    obs_head.delete(); obs_cnt.delete(); obs_runs.delete();
    done_cyc = -1; leak = 0; rdy_sh = 0;
    post_bad = 0; busy_drop = 0; aborted = 0;
    @(negedge clk);
    bs_valid[d] = 1'b0;
    start[d] = 1'b1;
    @(negedge clk);
    while (cyc < 400) begin
      start[d] = 1'b0;
      if (cyc == 1) begin
        c1_busy = busy[d]; c1_done = done[d]; c1_cnt = bcnt[d];
      end
      if (sen[d]) begin
        obs_head.push_back(head[d]);
        obs_cnt.push_back(int'(bcnt[d]));
        nsh++; run++;
        if (bs_ready[d]) rdy_sh++;
        if (nsh == start_at) start[d] = 1'b1;
        if (nsh == rst_at) begin
          rst[d] = 1'b1;
          bs_valid[d] = 1'b0;
          @(negedge clk);
          rst_se = sen[d]; rst_busy = busy[d];
          rst_done = done[d]; rst_cnt = bcnt[d];
          rst[d] = 1'b0;
          aborted = 1'b1;
          return;
        end
      end else begin
        if (run > 0) begin obs_runs.push_back(run); run = 0; end
        if (head[d]) leak++;
      end
      if (done[d]) begin done_cyc = cyc; break; end
      if (!busy[d]) busy_drop++;
      if (pend) begin
        pend = 0; widx++; wt = 0;
        if (gap == 0 && widx < tx_q.size()) bs_data[d] = tx_q[widx];
        else bs_valid[d] = 1'b0;
      end
      if (bs_ready[d] && widx < tx_q.size()) begin
        if (bs_valid[d]) pend = 1;
        else if (wt == gap) begin
          bs_valid[d] = 1'b1; bs_data[d] = tx_q[widx]; pend = 1;
        end else wt++;
      end
      @(negedge clk);
      cyc++;
    end
    bs_valid[d] = 1'b0;
    if (done_cyc < 0) return;
    // Words offered in DONE must be ignored.
    for (int i = 0; i < 4; i++) begin
      bs_valid[d] = 1'b1;
      bs_data[d] = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (sen[d] || bs_ready[d] || !done[d] ||
          int'(bcnt[d]) != clen(d)) post_bad++;
    end
    bs_valid[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0;
      bs_valid[d] = 1'b0; bs_data[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({bs_ready[d], head[d], sen[d], busy[d], done[d], bcnt[d]} !== 10'b0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: rdy=%b head=%b sen=%b busy=%b done=%b cnt=%0d, want all 0",
                 d, bs_ready[d], head[d], sen[d], busy[d], done[d], bcnt[d]);
      end
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy[0] !== 1'b0 || done[1] !== 1'b0 || bcnt[1] !== 5'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy0=%b done1=%b cnt1=%0d, want 0 0 0",
               busy[0], done[1], bcnt[1]);
    end
  endtask

  task automatic test_basic();
    bit spec_seq[16] = '{1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0};
    int errs;
    gap = 0; start_at = 0; rst_at = 0;
    chain_q = '{8'hA5, 8'h3C};
    build(0);
    run_load(0);
    errs = 0;
    for (int i = 0; i < 16; i++)
      if (i >= obs_head.size() || obs_head[i] !== spec_seq[i]) errs++;
    n_checks++;
    if (errs != 0 || obs_head.size() != 16) begin
      n_fail++;
      $display("FAIL basic_head_seq: %0d bits wrong, %0d shifted, want 0 wrong and 16",
               errs, obs_head.size());
    end
    n_checks++;
    if (done_cyc != exp_done) begin
      n_fail++;
      $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, exp_done);
    end
    n_checks++;
    if (int'(bcnt[0]) != CL0) begin
      n_fail++;
      $display("FAIL basic_bit_count: got %0d want %0d", bcnt[0], CL0);
    end
    n_checks++;
    if (c1_busy !== 1'b1 || c1_done !== 1'b0 || c1_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL basic_first_cycle: busy=%b done=%b cnt=%0d, want 1 0 0",
               c1_busy, c1_done, c1_cnt);
    end
    errs = 0;
    foreach (obs_cnt[i]) if (obs_cnt[i] != i) errs++;
    n_checks++;
    if (errs != 0 || leak != 0 || rdy_sh != 0 || busy_drop != 0) begin
      n_fail++;
      $display("FAIL basic_cycle_props: cnt_err=%0d leak=%0d rdy_in_shift=%0d busy_drop=%0d, want 0",
               errs, leak, rdy_sh, busy_drop);
    end
    n_checks++;
    if (post_bad != 0) begin
      n_fail++;
      $display("FAIL basic_done_hold: %0d bad cycles, want 0", post_bad);
    end
  endtask

  task automatic test_partial();
    int errs;
    gap = 0; start_at = 0; rst_at = 0;
    chain_q = '{8'hFF, 8'h00, 8'hFF};
    build(1);
    run_load(1);
    errs = 0;
    foreach (exp_bits[i])
      if (i >= obs_head.size() || obs_head[i] !== exp_bits[i]) errs++;
    n_checks++;
    if (errs != 0 || obs_head.size() != CL1) begin
      n_fail++;
      $display("FAIL partial_head_seq: %0d bits wrong, %0d shifted, want 0 and %0d",
               errs, obs_head.size(), CL1);
    end
    n_checks++;
    if (obs_runs.size() != 3 || obs_runs[2] != 4 || obs_runs[0] != 8) begin
      n_fail++;
      $display("FAIL partial_runs: %0d runs, last %0d, want 3 runs ending in 4",
               obs_runs.size(), obs_runs.size() > 0 ? obs_runs[obs_runs.size()-1] : -1);
    end
    n_checks++;
    if (done_cyc != exp_done) begin
      n_fail++;
      $display("FAIL partial_done_cycle: got %0d want %0d", done_cyc, exp_done);
    end
    n_checks++;
    if (post_bad != 0) begin
      n_fail++;
      $display("FAIL partial_ready_after: %0d bad cycles, want 0", post_bad);
    end
  endtask

  task automatic test_start_in_done();
    int errs;
    gap = 0; start_at = 0; rst_at = 0;
    rand_words(1);
    build(1);
    run_load(1);
    n_checks++;
    if (c1_done !== 1'b0 || c1_cnt !== 5'd0 || c1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clears: done=%b cnt=%0d busy=%b, want 0 0 1",
               c1_done, c1_cnt, c1_busy);
    end
    errs = 0;
    foreach (exp_bits[i])
      if (i >= obs_head.size() || obs_head[i] !== exp_bits[i]) errs++;
    n_checks++;
    if (errs != 0 || done_cyc != exp_done) begin
      n_fail++;
      $display("FAIL restart_load: %0d bits wrong, done at %0d want %0d",
               errs, done_cyc, exp_done);
    end
  endtask

  task automatic test_backpressure();
    int errs;
    gap = 3; start_at = 0; rst_at = 0;
    rand_words(0);
    build(0);
    run_load(0);
    errs = 0;
    foreach (exp_bits[i])
      if (i >= obs_head.size() || obs_head[i] !== exp_bits[i]) errs++;
    n_checks++;
    if (errs != 0 || obs_head.size() != CL0) begin
      n_fail++;
      $display("FAIL bp_head_seq: %0d bits wrong, %0d shifted", errs, obs_head.size());
    end
    n_checks++;
    if (obs_runs.size() != 2 || obs_runs[0] != 8 || obs_runs[1] != 8) begin
      n_fail++;
      $display("FAIL bp_shift_runs: %0d runs, want 2 runs of 8", obs_runs.size());
    end
    n_checks++;
    if (done_cyc != exp_done) begin
      n_fail++;
      $display("FAIL bp_done_cycle: got %0d want %0d", done_cyc, exp_done);
    end
    gap = 0;
  endtask

  task automatic test_ignored_start();
    int errs;
    gap = 0; start_at = 3; rst_at = 0;
    rand_words(0);
    build(0);
    run_load(0);
    errs = 0;
    foreach (exp_bits[i])
      if (i >= obs_head.size() || obs_head[i] !== exp_bits[i]) errs++;
    foreach (obs_cnt[i]) if (obs_cnt[i] != i) errs++;
    n_checks++;
    if (errs != 0 || done_cyc != exp_done) begin
      n_fail++;
      $display("FAIL start_in_shift: %0d errors, done at %0d want %0d",
               errs, done_cyc, exp_done);
    end
    start_at = 0;
  endtask

  task automatic test_reset_mid_load();
    int errs;
    gap = 0; start_at = 0; rst_at = 5;
    rand_words(1);
    build(1);
    run_load(1);
    n_checks++;
    if (!aborted || rst_se !== 1'b0 || rst_busy !== 1'b0 ||
        rst_done !== 1'b0 || rst_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL mid_reset: hit=%0d sen=%b busy=%b done=%b cnt=%0d, want 1 0 0 0 0",
               aborted, rst_se, rst_busy, rst_done, rst_cnt);
    end
    rst_at = 0;
    rand_words(1);
    build(1);
    run_load(1);
    errs = 0;
    foreach (exp_bits[i])
      if (i >= obs_head.size() || obs_head[i] !== exp_bits[i]) errs++;
    n_checks++;
    if (errs != 0 || done_cyc != exp_done) begin
      n_fail++;
      $display("FAIL reload_after_reset: %0d bits wrong, done at %0d want %0d",
               errs, done_cyc, exp_done);
    end
  endtask

  task automatic test_random();
    int errs, d;
    start_at = 0; rst_at = 0;
    for (int it = 0; it < 6; it++) begin
      d = it % 2;
      gap = $urandom_range(0, 2);
      rand_words(d);
      build(d);
      run_load(d);
      errs = 0;
      foreach (exp_bits[i])
        if (i >= obs_head.size() || obs_head[i] !== exp_bits[i]) errs++;
      n_checks++;
      if (errs != 0 || obs_head.size() != clen(d) || done_cyc != exp_done) begin
        n_fail++;
        $display("FAIL random_load[%0d]: %0d bits wrong, %0d shifted, done %0d want %0d",
                 it, errs, obs_head.size(), done_cyc, exp_done);
      end
    end
    gap = 0;
  endtask

`ifdef CCFF_LOADER_CRC_EN
  task automatic test_crc();
    for (int b = 0; b < 2; b++) begin
      bad_crc = (b == 1);
      rand_words(0);
      build(0);
      run_load(0);
      n_checks++;
      if (done_cyc != exp_done || crc_err[0] !== bad_crc) begin
        n_fail++;
        $display("FAIL crc_check[%0d]: done %0d want %0d, crc_err=%b want %b",
                 b, done_cyc, exp_done, crc_err[0], bad_crc);
      end
    end
    bad_crc = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_start_in_done();
    test_backpressure();
    test_ignored_start();
    test_reset_mid_load();
    test_random();
`ifdef CCFF_LOADER_CRC_EN
    test_crc();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
